// File: rtl/mem_cycle_sequencer.sv
// Memory cycle sequencer: owns every RAM access on the datapath. Runs the
// instruction fetch (MAR<-PC, read, IR<-RAM, PC<-nPC, nPC<-nPC+4) and the
// load/store cycles requested by the main control FSM, with an MFC timeout.
module mem_cycle_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5,
    parameter logic [5:0]  OP_OR   = 6'b000010,
    parameter logic [5:0]  OP_ADD  = 6'b000000,
    parameter logic [5:0]  OP_LD   = 6'b000000
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       fetch_req,
    input  logic       ls_req,
    input  logic [5:0] ls_op3,
    input  logic       ls_write,
    input  logic [1:0] pc_low,
    input  logic       MFC,
    output logic       MAR_Enable,
    output logic       IR_Enable,
    output logic       TEMP_Enable,
    output logic       PC_enable,
    output logic       NPC_enable,
    output logic [1:0] PC_In_Mux_select,
    output logic [1:0] ALUA_Mux_select,
    output logic [2:0] ALUB_Mux_select,
    output logic [5:0] ALU_op,
    output logic       RAM_enable,
    output logic [5:0] RAM_OpCode,
    output logic       busy,
    output logic       fetch_done,
    output logic       ls_done,
    output logic       mem_err
);

    typedef enum logic [2:0] {
        StIdle,
        StFAddr,
        StFWait,
        StFLatch,
        StLsWait,
        StLsLatch,
        StErr
    } state_e;

    // Last wait cycle allowed without MFC; the counter reads k-1 on wait cycle k.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       op3_q, op3_d;
    logic             write_q, write_d;

    // State, wait counter and latched load/store attributes.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op3_q   <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op3_q   <= op3_d;
            write_q <= write_d;
        end
    end

    // Next-state logic: arbitration in idle, MFC wait with timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op3_d   = op3_q;
        write_d = write_q;
        unique case (state_q)
            StIdle: begin
                // Load/store has priority; a concurrent fetch stays pending.
                if (ls_req) begin
                    state_d = StLsWait;
                    op3_d   = ls_op3;
                    write_d = ls_write;
                end else if (fetch_req) begin
                    state_d = StFAddr;
                end
            end
            StFAddr: begin
                state_d = (pc_low != 2'b00) ? StErr : StFWait;
            end
            StFWait, StLsWait: begin
                if (MFC) begin
                    state_d = (state_q == StFWait) ? StFLatch : StLsLatch;
                    cnt_d   = '0;
                end else begin
                    cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_d = StErr;
                    end
                end
            end
            StFLatch, StLsLatch: begin
                state_d = StIdle;
            end
            StErr: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        MAR_Enable       = 1'b0;
        IR_Enable        = 1'b0;
        TEMP_Enable      = 1'b0;
        PC_enable        = 1'b0;
        NPC_enable       = 1'b0;
        PC_In_Mux_select = 2'b00;
        ALUA_Mux_select  = 2'b00;
        ALUB_Mux_select  = 3'b000;
        ALU_op           = 6'b000000;
        RAM_enable       = 1'b0;
        RAM_OpCode       = 6'b000000;
        fetch_done       = 1'b0;
        ls_done          = 1'b0;
        mem_err          = 1'b0;
        busy             = (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
            end
            StFAddr: begin
                // MAR <- PC | PC
                ALUA_Mux_select = 2'b01;
                ALUB_Mux_select = 3'b011;
                ALU_op          = OP_OR;
                MAR_Enable      = 1'b1;
            end
            StFWait: begin
                RAM_enable = 1'b1;
                RAM_OpCode = OP_LD;
            end
            StFLatch: begin
                // IR <- RAM, PC <- nPC, nPC <- nPC + 4 on the same edge
                RAM_enable      = 1'b1;
                RAM_OpCode      = OP_LD;
                IR_Enable       = 1'b1;
                PC_enable       = 1'b1;
                NPC_enable      = 1'b1;
                ALUA_Mux_select = 2'b10;
                ALUB_Mux_select = 3'b110;
                ALU_op          = OP_ADD;
                fetch_done      = 1'b1;
            end
            StLsWait: begin
                RAM_enable = 1'b1;
                RAM_OpCode = op3_q;
            end
            StLsLatch: begin
                RAM_enable  = 1'b1;
                RAM_OpCode  = op3_q;
                TEMP_Enable = ~write_q;
                ls_done     = 1'b1;
            end
            StErr: begin
                mem_err = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_cycle_sequencer.sv
// Testbench for mem_cycle_sequencer: directed scenarios plus randomized
// fetch/load/store transactions against a transaction-level model, with a
// small behavioural datapath (PC, nPC, MAR, IR, TEMP, ALU, RAM) around the DUT.
module tb_mem_cycle_sequencer;

    localparam int unsigned TIMEOUT = 16;
    localparam logic [5:0]  OP_OR   = 6'b000010;
    localparam logic [5:0]  OP_ADD  = 6'b000000;
    localparam logic [5:0]  OP_LD   = 6'b000000;

    logic       Clk, Clr;
    logic       fetch_req, ls_req, ls_write, MFC;
    logic [5:0] ls_op3;
    logic [1:0] pc_low;
    logic       MAR_Enable, IR_Enable, TEMP_Enable, PC_enable, NPC_enable;
    logic [1:0] PC_In_Mux_select, ALUA_Mux_select;
    logic [2:0] ALUB_Mux_select;
    logic [5:0] ALU_op, RAM_OpCode;
    logic       RAM_enable, busy, fetch_done, ls_done, mem_err;

    mem_cycle_sequencer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (5),
        .OP_OR   (OP_OR),
        .OP_ADD  (OP_ADD),
        .OP_LD   (OP_LD)
    ) dut (
        .Clk              (Clk),
        .Clr              (Clr),
        .fetch_req        (fetch_req),
        .ls_req           (ls_req),
        .ls_op3           (ls_op3),
        .ls_write         (ls_write),
        .pc_low           (pc_low),
        .MFC              (MFC),
        .MAR_Enable       (MAR_Enable),
        .IR_Enable        (IR_Enable),
        .TEMP_Enable      (TEMP_Enable),
        .PC_enable        (PC_enable),
        .NPC_enable       (NPC_enable),
        .PC_In_Mux_select (PC_In_Mux_select),
        .ALUA_Mux_select  (ALUA_Mux_select),
        .ALUB_Mux_select  (ALUB_Mux_select),
        .ALU_op           (ALU_op),
        .RAM_enable       (RAM_enable),
        .RAM_OpCode       (RAM_OpCode),
        .busy             (busy),
        .fetch_done       (fetch_done),
        .ls_done          (ls_done),
        .mem_err          (mem_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       mar;
        logic       ir;
        logic       temp;
        logic       pc;
        logic       npc;
        logic [1:0] pcmux;
        logic [1:0] alua;
        logic [2:0] alub;
        logic [5:0] aluop;
        logic       ram;
        logic [5:0] ramop;
        logic       busy;
        logic       fd;
        logic       lsd;
        logic       err;
    } vec_t;

    vec_t  act, exp_vec;
    logic  exp_valid;
    string step_name;
    int    total, bad;

    always_comb begin
        act       = '0;
        act.mar   = MAR_Enable;
        act.ir    = IR_Enable;
        act.temp  = TEMP_Enable;
        act.pc    = PC_enable;
        act.npc   = NPC_enable;
        act.pcmux = PC_In_Mux_select;
        act.alua  = ALUA_Mux_select;
        act.alub  = ALUB_Mux_select;
        act.aluop = ALU_op;
        act.ram   = RAM_enable;
        act.ramop = RAM_OpCode;
        act.busy  = busy;
        act.fd    = fetch_done;
        act.lsd   = ls_done;
        act.err   = mem_err;
    end

    // Small datapath around the sequencer; RAM content is a fixed hash of the address.
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    logic [31:0] dp_pc   = 32'h10;
    logic [31:0] dp_npc  = 32'h14;
    logic [31:0] dp_mar  = 32'h0;
    logic [31:0] dp_ir   = 32'h0;
    logic [31:0] dp_temp = 32'h0;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        misalign;

    assign pc_low = misalign ? 2'b10 : dp_pc[1:0];

    always_comb begin
        alu_a   = (ALUA_Mux_select == 2'b01) ? dp_pc :
                  (ALUA_Mux_select == 2'b10) ? dp_npc : 32'h0;
        alu_b   = (ALUB_Mux_select == 3'b011) ? dp_pc :
                  (ALUB_Mux_select == 3'b110) ? 32'd4 : 32'h0;
        alu_out = (ALU_op == OP_OR) ? (alu_a | alu_b) : (alu_a + alu_b);
    end

    always @(posedge Clk) begin
        if (MAR_Enable)  dp_mar  <= alu_out;
        if (IR_Enable)   dp_ir   <= ram_word(dp_mar);
        if (TEMP_Enable) dp_temp <= ram_word(dp_mar);
        if (PC_enable && PC_In_Mux_select == 2'b00) dp_pc <= dp_npc;
        if (NPC_enable)  dp_npc  <= alu_out;
    end

    // Architectural expectations for the datapath registers.
    logic [31:0] exp_pc   = 32'h10;
    logic [31:0] exp_npc  = 32'h14;
    logic [31:0] exp_mar  = 32'h0;
    logic [31:0] exp_ir   = 32'h0;
    logic [31:0] exp_temp = 32'h0;

    // Per-cycle output compare, away from the active edge.
    always @(negedge Clk) begin
        if (exp_valid) begin
            total++;
            if (act !== exp_vec) begin
                bad++;
                $display("FAIL %s outputs: got %h want %h at %0t", step_name, act, exp_vec,
                         $time);
            end
        end
    end

    task automatic chk32(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic chk_vec(input string nm, input vec_t e);
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, e);
        end
    endtask

    task automatic check_regs(input string nm);
        chk32({nm, "_pc"},   dp_pc,   exp_pc);
        chk32({nm, "_npc"},  dp_npc,  exp_npc);
        chk32({nm, "_mar"},  dp_mar,  exp_mar);
        chk32({nm, "_ir"},   dp_ir,   exp_ir);
        chk32({nm, "_temp"}, dp_temp, exp_temp);
    endtask

    // Expected output vectors for each phase of a memory cycle.
    function automatic vec_t v_idle();
        return '0;
    endfunction

    function automatic vec_t v_faddr();
        vec_t v = '0;
        v.mar = 1'b1; v.alua = 2'b01; v.alub = 3'b011; v.aluop = OP_OR; v.busy = 1'b1;
        return v;
    endfunction

    function automatic vec_t v_fwait();
        vec_t v = '0;
        v.ram = 1'b1; v.ramop = OP_LD; v.busy = 1'b1;
        return v;
    endfunction

    function automatic vec_t v_flatch();
        vec_t v = '0;
        v.ram = 1'b1; v.ramop = OP_LD; v.ir = 1'b1; v.pc = 1'b1; v.npc = 1'b1;
        v.alua = 2'b10; v.alub = 3'b110; v.aluop = OP_ADD; v.fd = 1'b1; v.busy = 1'b1;
        return v;
    endfunction

    function automatic vec_t v_lswait(input logic [5:0] op3);
        vec_t v = '0;
        v.ram = 1'b1; v.ramop = op3; v.busy = 1'b1;
        return v;
    endfunction

    function automatic vec_t v_lslatch(input logic [5:0] op3, input logic w);
        vec_t v = '0;
        v.ram = 1'b1; v.ramop = op3; v.temp = ~w; v.lsd = 1'b1; v.busy = 1'b1;
        return v;
    endfunction

    function automatic vec_t v_err();
        vec_t v = '0;
        v.err = 1'b1; v.busy = 1'b1;
        return v;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    // One clock cycle: drive inputs, publish the expected outputs, advance.
    task automatic step(input vec_t e, input logic f, input logic l, input logic [5:0] op3,
                        input logic w, input logic mfc);
        fetch_req = f;
        ls_req    = l;
        ls_op3    = op3;
        ls_write  = w;
        MFC       = mfc;
        exp_vec   = e;
        exp_valid = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    // Fetch: d = wait cycle on which MFC rises (0 = never); mis = misaligned PC.
    task automatic do_fetch(input int d, input bit mis, input string nm);
        logic mfc;
        bit   done;
        step_name = nm;
        step(v_idle(), 1'b1, 1'b0, rop(), rbit(), rbit());
        misalign = mis;
        step(v_faddr(), rbit(), rbit(), rop(), rbit(), rbit());
        misalign = 1'b0;
        exp_mar  = exp_pc;
        if (mis) begin
            step(v_err(), rbit(), rbit(), rop(), rbit(), rbit());
            check_regs(nm);
            return;
        end
        done = 1'b0;
        for (int k = 1; k <= int'(TIMEOUT) && !done; k++) begin
            mfc = (k == d);
            step(v_fwait(), rbit(), rbit(), rop(), rbit(), mfc);
            done = mfc;
        end
        if (done) begin
            step(v_flatch(), rbit(), rbit(), rop(), rbit(), rbit());
            exp_ir  = ram_word(exp_mar);
            exp_pc  = exp_npc;
            exp_npc = exp_npc + 32'd4;
        end else begin
            step(v_err(), rbit(), rbit(), rop(), rbit(), rbit());
        end
        check_regs(nm);
    endtask

    // Load/store: MAR already holds the address; fetch_too raises fetch_req alongside.
    task automatic do_ls(input int d, input logic [5:0] op3, input logic w, input logic fetch_too,
                         input string nm);
        logic mfc;
        bit   done;
        step_name = nm;
        step(v_idle(), fetch_too, 1'b1, op3, w, rbit());
        done = 1'b0;
        for (int k = 1; k <= int'(TIMEOUT) && !done; k++) begin
            mfc = (k == d);
            step(v_lswait(op3), rbit(), rbit(), rop(), rbit(), mfc);
            done = mfc;
        end
        if (done) begin
            step(v_lslatch(op3, w), rbit(), rbit(), rop(), rbit(), rbit());
            if (!w) exp_temp = ram_word(exp_mar);
        end else begin
            step(v_err(), rbit(), rbit(), rop(), rbit(), rbit());
        end
        check_regs(nm);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_valid = 1'b0;
        exp_vec   = '0;
        misalign  = 1'b0;
        step_name = "reset";
        fetch_req = 1'b0;
        ls_req    = 1'b0;
        ls_op3    = 6'd0;
        ls_write  = 1'b0;
        MFC       = 1'b0;
        Clr       = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk_vec("reset_state", v_idle());
        Clr = 1'b1;

        // Fetch from PC=0x10 with MFC on the second wait cycle.
        do_fetch(2, 1'b0, "fetch_basic");
        chk32("fetch_basic_mar_lit", dp_mar, 32'h10);
        chk32("fetch_basic_pc_lit",  dp_pc,  32'h14);
        chk32("fetch_basic_npc_lit", dp_npc, 32'h18);

        // Both requests: the store goes first, then the pending fetch.
        do_ls(3, 6'b000100, 1'b1, 1'b1, "both_store");
        do_fetch(1, 1'b0, "both_fetch");
        chk32("both_fetch_pc_lit", dp_pc, 32'h18);

        // Load with MFC never arriving: timeout after TIMEOUT wait cycles.
        do_ls(0, 6'b000000, 1'b0, 1'b0, "load_timeout");

        // Misaligned fetch goes straight to the error pulse.
        do_fetch(1, 1'b1, "fetch_misaligned");

        // Reset in the middle of a fetch wait.
        step_name = "reset_mid_wait";
        step(v_idle(), 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        step(v_faddr(), 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        exp_mar = exp_pc;
        step(v_fwait(), 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        step(v_fwait(), 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        exp_valid = 1'b0;
        fetch_req = 1'b1;
        ls_req    = 1'b1;
        MFC       = 1'b1;
        Clr       = 1'b0;
        #1;
        chk_vec("reset_immediate", v_idle());
        exp_vec   = v_idle();
        exp_valid = 1'b1;
        @(posedge Clk);
        #1;
        fetch_req = 1'b0;
        ls_req    = 1'b0;
        MFC       = 1'b0;
        Clr       = 1'b1;
        repeat (3) step(v_idle(), 1'b0, 1'b0, rop(), rbit(), rbit());
        check_regs("after_reset");
        do_ls(0, 6'b001101, 1'b0, 1'b0, "timeout_after_reset");

        // Load with MFC on the first wait cycle.
        do_ls(1, 6'b001001, 1'b0, 1'b0, "load_fast");
        // Boundary: MFC on the last permitted wait cycle completes normally.
        do_fetch(int'(TIMEOUT), 1'b0, "fetch_mfc_last");

        // Randomized transactions.
        for (int i = 0; i < 250; i++) begin
            int kind;
            int d;
            kind = int'($urandom_range(0, 9));
            d    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
            step_name = "idle_gap";
            repeat ($urandom_range(0, 2)) step(v_idle(), 1'b0, 1'b0, rop(), rbit(), rbit());
            if (kind <= 4) begin
                do_fetch(d, (kind == 0), "rand_fetch");
            end else begin
                do_ls(d, rop(), (kind >= 8), rbit(), "rand_ls");
            end
        end

        exp_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
